// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FILL
  } state_t;

  localparam int ADDR_BITS          = 32;
  localparam int WORD_BITS          = 32;
  localparam int LINE_BITS          = 128;
  localparam int OFFSET_BITS        = 4;
  localparam int INDEX_BITS_DEFAULT = 4;

  function automatic int tag_bits(input int index_bits);
    return ADDR_BITS - index_bits - OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dcache_meta_array.sv
// Valid/dirty/tag storage: synchronous clear of valid and dirty, combinational read, one write port.
module dcache_meta_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_BITS   = tag_bits(INDEX_BITS_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_BITS-1:0]   rd_tag,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic [TAG_BITS-1:0]   wr_tag
);

  localparam int NUM_LINES = 1 << INDEX_BITS;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_BITS-1:0]  tag_q [NUM_LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tags need no reset: a cleared valid bit masks whatever they hold.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      tag_q[wr_idx] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM stage.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cpu_read,
  input  logic           cpu_write,
  input  logic [31:0]    cpu_addr,
  input  logic [31:0]    cpu_wdata,
  output logic [31:0]    cpu_rdata,
  output logic           mem_stall,
  output logic           mem_req,
  output logic           mem_we,
  output logic [31:0]    mem_addr,
  output logic [127:0]   mem_wdata,
  input  logic [127:0]   mem_rdata,
  input  logic           mem_ack
);

  localparam int TAG_BITS      = tag_bits(INDEX_BITS);
  localparam int NUM_LINES     = 1 << INDEX_BITS;
  localparam int WORD_SEL_BITS = $clog2(LINE_WORDS);

  state_t state;

  logic [TAG_BITS-1:0]      cpu_tag;
  logic [INDEX_BITS-1:0]    idx;
  logic [WORD_SEL_BITS-1:0] word_sel;
  logic [6:0]               word_lsb;
  logic                     unused_addr_bits;

  logic                rd_valid;
  logic                rd_dirty;
  logic [TAG_BITS-1:0] rd_tag;
  logic                meta_we;
  logic                meta_dirty;
  logic [TAG_BITS-1:0] meta_tag;

  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [LINE_BITS-1:0] line_rd;

  logic access;
  logic hit;
  logic write_hit;
  logic ack_ok;

  assign cpu_tag          = cpu_addr[31 -: TAG_BITS];
  assign idx              = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign word_sel         = cpu_addr[2 +: WORD_SEL_BITS];
  assign word_lsb         = {word_sel, 5'b0};
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign access    = cpu_read | cpu_write;
  assign hit       = rd_valid && (rd_tag == cpu_tag);
  assign write_hit = (state == IDLE) && cpu_write && hit;
  assign ack_ok    = mem_req && mem_ack;
  assign line_rd   = data_q[idx];

  dcache_meta_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_meta (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .wr_en    (meta_we),
    .wr_idx   (idx),
    .wr_valid (1'b1),
    .wr_dirty (meta_dirty),
    .wr_tag   (meta_tag)
  );

  always_comb begin
    meta_we    = 1'b0;
    meta_dirty = 1'b0;
    meta_tag   = cpu_tag;
    unique case (state)
      IDLE: begin
        if (write_hit) begin
          meta_we    = 1'b1;
          meta_dirty = 1'b1;
        end
      end
      WRITEBACK: begin
        // Victim stays resident and valid until the fill replaces it.
        if (ack_ok) begin
          meta_we  = 1'b1;
          meta_tag = rd_tag;
        end
      end
      FILL: begin
        if (ack_ok) meta_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_stall = (state != IDLE) || (access && !hit);
    cpu_rdata = '0;
    if (state == IDLE && cpu_read && hit) cpu_rdata = line_rd[word_lsb +: WORD_BITS];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (write_hit) data_q[idx][word_lsb +: WORD_BITS] <= cpu_wdata;
      else if (state == FILL && ack_ok) data_q[idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access && !hit) begin
            mem_req <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state     <= WRITEBACK;
              mem_we    <= 1'b1;
              mem_addr  <= {rd_tag, idx, {OFFSET_BITS{1'b0}}};
              mem_wdata <= line_rd;
            end else begin
              state    <= FILL;
              mem_we   <= 1'b0;
              mem_addr <= {cpu_tag, idx, {OFFSET_BITS{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= FILL;
          end
        end
        FILL: begin
          // Entered with mem_req low after a write-back: the idle cycle forms the handshake gap.
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {cpu_tag, idx, {OFFSET_BITS{1'b0}}};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: scripted CPU accesses plus a memory responder with a transaction scoreboard.
module tb_dcache_ctrl;

  logic         clk;
  logic         reset;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         mem_stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
  } txn_t;

  txn_t sb_q[$];

  localparam int MEM_LAT = 3;

  logic [127:0] l40, l440, l80, l880, lc0;

  dcache_ctrl #(
    .INDEX_BITS (4),
    .LINE_WORDS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .mem_stall (mem_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: acks MEM_LAT cycles after a request is first seen, drops everything on reset.
  initial begin : responder
    bit   active;
    int   cnt;
    txn_t t;
    active    = 1'b0;
    cnt       = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (reset) begin
        active = 1'b0;
        cnt    = 0;
      end else if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got we=%0b addr=%h, expected no request", mem_we, mem_addr);
            t.rdata = '0;
          end else begin
            t = sb_q.pop_front();
            if (mem_we !== t.we || mem_addr !== t.addr || (t.we && mem_wdata !== t.wdata)) begin
              errors++;
              $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, expected we=%0b addr=%h wdata=%h",
                       mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wdata);
            end
          end
        end else begin
          cnt++;
        end
        if (active && cnt == MEM_LAT) begin
          mem_ack   = 1'b1;
          mem_rdata = t.rdata;
          active    = 1'b0;
        end
      end
    end
  end

  task automatic push_txn(input logic we, input logic [31:0] addr, input logic [127:0] wdata,
                          input logic [127:0] rdata);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.rdata = rdata;
    sb_q.push_back(t);
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_stalls,
                           input logic chk_rd, input logic [31:0] exp_rd, input string name);
    int stalls;
    bit done;
    stalls = 0;
    done   = 1'b0;
    @(posedge clk);
    #1;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected %0d", name, stalls, exp_stalls);
    end else if (stalls !== exp_stalls) begin
      errors++;
      $display("FAIL %s_stall: got %0d stall cycles, expected %0d", name, stalls, exp_stalls);
    end
    if (chk_rd) begin
      checks++;
      if (cpu_rdata !== exp_rd) begin
        errors++;
        $display("FAIL %s_rdata: got %h, expected %h", name, cpu_rdata, exp_rd);
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%0b we=%0b stall=%0b, expected 0 0 0", mem_req, mem_we, mem_stall);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 128'h0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h, expected zeros", mem_addr, mem_wdata, cpu_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_access: got stall=%0b req=%0b, expected 0 0", mem_stall, mem_req);
    end
  endtask

  task automatic test_cold_miss();
    push_txn(1'b0, 32'h40, '0, l40);
    do_access(1'b1, 1'b0, 32'h40, '0, 5, 1'b1, 32'h1111, "cold_miss");
  endtask

  task automatic test_read_hit();
    do_access(1'b1, 1'b0, 32'h48, '0, 0, 1'b1, 32'h3333, "read_hit");
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL read_hit_req: got mem_req=%0b, expected 0", mem_req);
    end
  endtask

  task automatic test_dirty_evict();
    logic [127:0] v;
    v = l40;
    v[63:32] = 32'hDEADBEEF;
    do_access(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 0, 1'b0, '0, "write_hit");
    push_txn(1'b1, 32'h40, v, '0);
    push_txn(1'b0, 32'h440, '0, l440);
    do_access(1'b1, 1'b0, 32'h440, '0, 10, 1'b1, l440[31:0], "dirty_evict");
  endtask

  task automatic test_write_miss();
    logic [127:0] v;
    v = l80;
    v[31:0] = 32'hA5A5A5A5;
    push_txn(1'b0, 32'h80, '0, l80);
    do_access(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5, 1'b0, '0, "write_miss");
    do_access(1'b1, 1'b0, 32'h80, '0, 0, 1'b1, 32'hA5A5A5A5, "write_miss_rd");
    do_access(1'b1, 1'b0, 32'h84, '0, 0, 1'b1, l80[63:32], "write_miss_merge");
    push_txn(1'b1, 32'h80, v, '0);
    push_txn(1'b0, 32'h880, '0, l880);
    do_access(1'b1, 1'b0, 32'h880, '0, 10, 1'b1, l880[31:0], "write_miss_evict");
  endtask

  task automatic test_both_set();
    logic [127:0] v;
    v = l440;
    v[95:64] = 32'h12345678;
    do_access(1'b1, 1'b1, 32'h448, 32'h12345678, 0, 1'b0, '0, "both_write");
    do_access(1'b1, 1'b0, 32'h448, '0, 0, 1'b1, 32'h12345678, "both_rd");
    push_txn(1'b1, 32'h440, v, '0);
    push_txn(1'b0, 32'h40, '0, l40);
    do_access(1'b1, 1'b0, 32'h48, '0, 10, 1'b1, 32'h3333, "both_evict");
  endtask

  task automatic test_reset_mid_fill();
    push_txn(1'b0, 32'hC0, '0, lc0);
    @(posedge clk);
    #1;
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = 32'hC0;
    @(negedge clk);
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_fill_stall: got %0b, expected 1", mem_stall);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill_req: got req=%0b we=%0b, expected 1 0", mem_req, mem_we);
    end
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_fill_abort: got req=%0b stall=%0b, expected 0 0", mem_req, mem_stall);
    end
    reset = 1'b0;
    push_txn(1'b0, 32'hC0, '0, lc0);
    do_access(1'b1, 1'b0, 32'hC0, '0, 5, 1'b1, lc0[31:0], "rst_refill");
  endtask

  initial begin
    l40  = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    l440 = {32'h0440_0003, 32'h0440_0002, 32'h0440_0001, 32'h0440_0000};
    l80  = {32'h0080_0003, 32'h0080_0002, 32'h0080_0001, 32'h0080_0000};
    l880 = {32'h0880_0003, 32'h0880_0002, 32'h0880_0001, 32'h0880_0000};
    lc0  = {32'h00C0_0003, 32'h00C0_0002, 32'h00C0_0001, 32'h00C0_0000};

    test_reset();
    test_cold_miss();
    test_read_hit();
    test_dirty_evict();
    test_write_miss();
    test_both_set();
    go_idle();
    test_reset_mid_fill();
    go_idle();
    repeat (5) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending transactions, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
